// File: rtl/frame_aligner.sv
// frame_aligner: aligns an ADC frame-clock deserializer by comparing each
// 8-bit frame word against PATTERN and issuing single-cycle bitslip pulses
// until the word matches. Reports lock, lock loss and alignment failure.
// Optional build macro FRAME_ALIGN_STATS_EN adds mismatch_cnt_o and
// relock_cnt_o statistics ports; without it the block has no stats logic.
module frame_aligner #(
  parameter logic [7:0]  PATTERN       = 8'hF0,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned LOSS_COUNT    = 4,
  parameter int unsigned MAX_SLIPS     = 8
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       en,
  input  logic [7:0] frame_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic       error_o,
  output logic [3:0] slip_count_o
`ifdef FRAME_ALIGN_STATS_EN
  ,
  output logic [15:0] mismatch_cnt_o,
  output logic [7:0]  relock_cnt_o
`endif
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] LOCK_LAST   = 8'(LOCK_COUNT - 1);
  localparam logic [7:0] LOSS_LAST   = 8'(LOSS_COUNT - 1);
  localparam logic [3:0] SLIP_MAX    = 4'(MAX_SLIPS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    LOCKED = 3'd4,
    FAIL   = 3'd5
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] match_cnt;
  logic [7:0] match_cnt_next;
  logic [7:0] miss_cnt;
  logic [7:0] miss_cnt_next;
  logic [3:0] slip_cnt;
  logic [3:0] slip_cnt_next;
  logic [3:0] settle_cnt;
  logic [3:0] settle_cnt_next;
  logic       match;

  assign match = (frame_i == PATTERN);

  // Next-state and next-counter logic; en=0 overrides every state.
  always_comb begin
    state_next      = state;
    match_cnt_next  = match_cnt;
    miss_cnt_next   = miss_cnt;
    slip_cnt_next   = slip_cnt;
    settle_cnt_next = settle_cnt;
    if (!en) begin
      state_next      = IDLE;
      match_cnt_next  = 8'd0;
      miss_cnt_next   = 8'd0;
      slip_cnt_next   = 4'd0;
      settle_cnt_next = 4'd0;
    end else begin
      case (state)
        IDLE: begin
          match_cnt_next  = 8'd0;
          miss_cnt_next   = 8'd0;
          slip_cnt_next   = 4'd0;
          settle_cnt_next = 4'd0;
          state_next      = CHECK;
        end
        CHECK: begin
          if (match) begin
            if (match_cnt == LOCK_LAST) begin
              state_next     = LOCKED;
              match_cnt_next = 8'd0;
              miss_cnt_next  = 8'd0;
            end else begin
              match_cnt_next = match_cnt + 8'd1;
            end
          end else begin
            match_cnt_next = 8'd0;
            if (slip_cnt >= SLIP_MAX) begin
              state_next = FAIL;
            end else begin
              state_next = SLIP;
            end
          end
        end
        SLIP: begin
          // The pulse is already on the output this cycle; count it and
          // give the deserializer pipeline time to show the new word.
          slip_cnt_next   = (slip_cnt < SLIP_MAX) ? (slip_cnt + 4'd1) : slip_cnt;
          settle_cnt_next = SETTLE_INIT;
          state_next      = SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state_next     = CHECK;
            match_cnt_next = 8'd0;
          end else begin
            settle_cnt_next = settle_cnt - 4'd1;
          end
        end
        LOCKED: begin
          if (match) begin
            miss_cnt_next = 8'd0;
          end else if (miss_cnt == LOSS_LAST) begin
            // Lock lost: start a fresh attempt with a full slip budget.
            state_next     = CHECK;
            miss_cnt_next  = 8'd0;
            match_cnt_next = 8'd0;
            slip_cnt_next  = 4'd0;
          end else begin
            miss_cnt_next = miss_cnt + 8'd1;
          end
        end
        FAIL: begin
          state_next = FAIL;
        end
        default: begin
          state_next      = IDLE;
          match_cnt_next  = 8'd0;
          miss_cnt_next   = 8'd0;
          slip_cnt_next   = 4'd0;
          settle_cnt_next = 4'd0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Internal counters.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      match_cnt  <= 8'd0;
      miss_cnt   <= 8'd0;
      slip_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
    end else begin
      match_cnt  <= match_cnt_next;
      miss_cnt   <= miss_cnt_next;
      slip_cnt   <= slip_cnt_next;
      settle_cnt <= settle_cnt_next;
    end
  end

  // Outputs registered from the next state so they line up with the state.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      bitslip_o    <= 1'b0;
      locked_o     <= 1'b0;
      error_o      <= 1'b0;
      slip_count_o <= 4'd0;
    end else begin
      bitslip_o    <= (state_next == SLIP);
      locked_o     <= (state_next == LOCKED);
      error_o      <= (state_next == FAIL);
      slip_count_o <= slip_cnt_next;
    end
  end

`ifdef FRAME_ALIGN_STATS_EN
  logic locked_miss;
  logic lock_loss;

  assign locked_miss = en && (state == LOCKED) && !match;
  assign lock_loss   = locked_miss && (miss_cnt == LOSS_LAST);

  // Saturating statistics counters, cleared by reset or en=0.
  always_ff @(posedge CLK) begin
    if (!RST_N || !en) begin
      mismatch_cnt_o <= 16'd0;
      relock_cnt_o   <= 8'd0;
    end else begin
      if (locked_miss && (mismatch_cnt_o != 16'hFFFF)) begin
        mismatch_cnt_o <= mismatch_cnt_o + 16'd1;
      end
      if (lock_loss && (relock_cnt_o != 8'hFF)) begin
        relock_cnt_o <= relock_cnt_o + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// Self-checking bench for frame_aligner: behavioural model plus directed
// scenarios (pre-aligned, misaligned, unalignable, lock loss, reset mid-settle).
module tb_frame_aligner;

  localparam logic [7:0] PAT    = 8'hF0;
  localparam int         SETTLE = 4;
  localparam int         LOCKN  = 16;
  localparam int         LOSSN  = 4;
  localparam int         MAXS   = 8;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       en;
  logic [7:0] frame_i;
  logic       bitslip_o;
  logic       locked_o;
  logic       error_o;
  logic [3:0] slip_count_o;
`ifdef FRAME_ALIGN_STATS_EN
  logic [15:0] mismatch_cnt_o;
  logic [7:0]  relock_cnt_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  frame_aligner dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .en           (en),
    .frame_i      (frame_i),
    .bitslip_o    (bitslip_o),
    .locked_o     (locked_o),
    .error_o      (error_o),
    .slip_count_o (slip_count_o)
`ifdef FRAME_ALIGN_STATS_EN
    ,
    .mismatch_cnt_o (mismatch_cnt_o),
    .relock_cnt_o   (relock_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << (n % 8);
    return d[15:8];
  endfunction

  // ---------------- behavioural model ----------------
  bit chk_en   = 1'b0;
  bit m_idle   = 1'b1;
  bit m_locked = 1'b0;
  bit m_failed = 1'b0;
  bit m_pulse  = 1'b0;
  int m_slips  = 0;
  int m_run    = 0;
  int m_miss   = 0;
  int m_quiet  = 0;
  int m_mis    = 0;
  int m_relock = 0;

  // Model advance on every rising edge from the sampled inputs.
  always @(posedge CLK) begin
    if (RST_N !== 1'b1 || en !== 1'b1) begin
      m_idle = 1'b1; m_locked = 1'b0; m_failed = 1'b0; m_pulse = 1'b0;
      m_slips = 0; m_run = 0; m_miss = 0; m_quiet = 0; m_mis = 0; m_relock = 0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_failed) begin
      m_pulse = 1'b0;
    end else if (m_pulse) begin
      m_pulse = 1'b0;
      m_slips++;
      m_quiet = SETTLE;
    end else if (m_quiet > 0) begin
      m_quiet--;
    end else if (m_locked) begin
      if (frame_i == PAT) begin
        m_miss = 0;
      end else begin
        m_miss++;
        if (m_mis < 65535) m_mis++;
        if (m_miss == LOSSN) begin
          m_locked = 1'b0; m_miss = 0; m_run = 0; m_slips = 0;
          if (m_relock < 255) m_relock++;
        end
      end
    end else if (frame_i == PAT) begin
      m_run++;
      if (m_run == LOCKN) begin
        m_locked = 1'b1; m_run = 0; m_miss = 0;
      end
    end else begin
      m_run = 0;
      if (m_slips == MAXS) m_failed = 1'b1;
      else m_pulse = 1'b1;
    end
  end

  // ---------------- compare process ----------------
  int n_pulses   = 0;
  int last_pulse = -100;
  int min_gap    = 1000;

  // Per-cycle comparison against the model and pulse bookkeeping.
  always @(negedge CLK) begin
    cyc++;
    if (chk_en) begin
      chk("bitslip_o", bitslip_o, m_pulse);
      chk("locked_o", locked_o, m_locked);
      chk("error_o", error_o, m_failed);
      chk("slip_count_o", slip_count_o, m_slips);
`ifdef FRAME_ALIGN_STATS_EN
      chk("mismatch_cnt_o", mismatch_cnt_o, m_mis);
      chk("relock_cnt_o", relock_cnt_o, m_relock);
`endif
    end
    if (bitslip_o === 1'b1) begin
      if (cyc - last_pulse < min_gap) min_gap = cyc - last_pulse;
      n_pulses++;
      last_pulse = cyc;
    end
  end

  // ---------------- deserializer model ----------------
  bit mode = 1'b0;
  int rot  = 0;

  // Rotates the presented word one bit per bitslip pulse when enabled.
  always @(negedge CLK) begin
    if (mode) begin
      if (bitslip_o === 1'b1) rot = (rot + 7) % 8;
      frame_i = rotl(PAT, rot);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge CLK);
      #1;
    end
  endtask

  task automatic restart_counts();
    n_pulses = 0; last_pulse = -100; min_gap = 1000;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    RST_N = 1'b0; en = 1'b0; frame_i = 8'h00;
    tick(3);
    chk_en = 1'b1;
    chk("rst_bitslip", bitslip_o, 1'b0);
    chk("rst_locked", locked_o, 1'b0);
    chk("rst_error", error_o, 1'b0);
    chk("rst_slipcnt", slip_count_o, 4'd0);
    RST_N = 1'b1;
    tick(2);

    // Pre-aligned: lock at cycle 17, no pulses.
    frame_i = PAT; restart_counts(); en = 1'b1;
    tick(16);
    chk("pre_locked_c16", locked_o, 1'b0);
    tick(1);
    chk("pre_locked_c17", locked_o, 1'b1);
    chk("model_lock_c17", m_locked, 1'b1);
    chk("pre_pulses", n_pulses, 0);
    chk("pre_slipcnt", slip_count_o, 4'd0);

    // Misaligned by three slips.
    en = 1'b0; tick(2);
    rot = 3; frame_i = rotl(PAT, 3); mode = 1'b1; restart_counts(); en = 1'b1;
    for (int i = 0; i < 200 && locked_o !== 1'b1; i++) tick(1);
    chk("mis_locked", locked_o, 1'b1);
    chk("mis_pulses", n_pulses, 3);
    chk("mis_slipcnt", slip_count_o, 4'd3);
    chk("mis_gap_ok", (min_gap >= SETTLE + 1), 1'b1);

    // Unalignable input.
    en = 1'b0; mode = 1'b0; tick(2);
    frame_i = 8'hAA; restart_counts(); en = 1'b1;
    for (int i = 0; i < 300 && error_o !== 1'b1; i++) tick(1);
    chk("fail_error", error_o, 1'b1);
    chk("fail_pulses", n_pulses, 8);
    tick(30);
    chk("fail_no_9th", n_pulses, 8);
    chk("fail_sticky", error_o, 1'b1);
    en = 1'b0; tick(1);
    chk("fail_clear", error_o, 1'b0);
    chk("fail_clear_cnt", slip_count_o, 4'd0);
    restart_counts(); en = 1'b1;
    tick(2);
    chk("retry_pulse", bitslip_o, 1'b1);
    chk("retry_pulses", n_pulses, 1);

    // Lock loss.
    en = 1'b0; tick(2);
    frame_i = PAT; en = 1'b1;
    tick(18);
    chk("loss_pre_lock", locked_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      frame_i = 8'h0F; tick(1);
      chk("loss_hold_miss", locked_o, 1'b1);
    end
    frame_i = PAT; tick(1);
    chk("loss_hold_match", locked_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      frame_i = 8'h0F; tick(1);
      chk("loss_seq", locked_o, (i < 3) ? 1'b1 : 1'b0);
    end
    chk("loss_slipcnt", slip_count_o, 4'd0);
`ifdef FRAME_ALIGN_STATS_EN
    chk("stats_mismatch", mismatch_cnt_o, 16'd7);
    chk("stats_relock", relock_cnt_o, 8'd1);
`endif
    tick(1);
    chk("loss_realign_pulse", bitslip_o, 1'b1);
    frame_i = PAT;
    for (int i = 0; i < 100 && locked_o !== 1'b1; i++) tick(1);
    chk("loss_relock", locked_o, 1'b1);

    // Reset mid-SETTLE.
    en = 1'b0; tick(2);
    frame_i = 8'hAA; en = 1'b1;
    for (int i = 0; i < 20 && bitslip_o !== 1'b1; i++) tick(1);
    chk("rs_first_pulse", bitslip_o, 1'b1);
    tick(1);
    RST_N = 1'b0; tick(1);
    chk("rs_bitslip", bitslip_o, 1'b0);
    chk("rs_locked", locked_o, 1'b0);
    chk("rs_error", error_o, 1'b0);
    chk("rs_slipcnt", slip_count_o, 4'd0);
    RST_N = 1'b1; tick(1);
    chk("rs_check_nopulse", bitslip_o, 1'b0);
    tick(1);
    chk("rs_resume_pulse", bitslip_o, 1'b1);
    chk("rs_resume_cnt", slip_count_o, 4'd0);

    en = 1'b0; tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
